// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, FSM state encoding
// and opcode classification helpers.
// Imported by serial_alu_n and serial_bit_slice.
package alu_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Opcodes 110 and 111 are not assigned.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return (op == 3'b110) || (op == 3'b111);
  endfunction

  // Ops that produce no bit-serial work and jump straight to FIN.
  function automatic logic is_skip_op(input logic [2:0] op);
    return (op == OP_NOP) || is_illegal_op(op);
  endfunction

endpackage

// File: rtl/serial_bit_slice.sv
// Combinational 1-bit ALU cell used once per clock by the serial ALU.
// Latency: none (pure combinational).
// Backpressure: none; the caller sequences the bits.
module serial_bit_slice
  import alu_pkg::*;
(
  input  logic       ai,
  input  logic       bi,
  input  logic       ci,
  input  logic [2:0] op,
  output logic       ri,
  output logic       co
);

  logic bx;

  // SUB is done as a + ~b + 1; the +1 comes from the carry flop preset.
  always_comb begin
    bx = (op == OP_SUB) ? ~bi : bi;
    ri = 1'b0;
    co = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        ri = ai ^ bx ^ ci;
        co = (ai & bx) | (ai & ci) | (bx & ci);
      end
      OP_XOR:  ri = ai ^ bi;
      OP_AND:  ri = ai & bi;
      OP_OR:   ri = ai | bi;
      default: ri = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_n.sv
// Parametrised bit-serial ALU, LSB first, one bit per clock.
// Latency: start at edge 0 -> done high in the cycle after edge WIDTH (NOP/illegal: after edge 0).
// Backpressure: start is only honoured in IDLE; starts during RUN/FIN are dropped, not queued.
module serial_alu_n
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             sign,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] work_q, work_next;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             ri, co;
  logic             last_bit;
  logic             is_arith;

  // Operands are shifted right each cycle so the current bit is always at
  // index 0; the working register fills from the top, so after WIDTH
  // shifts bit i of the result sits at index i.
  serial_bit_slice u_slice (
    .ai (a_sh[0]),
    .bi (b_sh[0]),
    .ci (c_q),
    .op (op_q),
    .ri (ri),
    .co (co)
  );

  assign work_next = {ri, work_q[WIDTH-1:1]};
  assign last_bit  = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH - 1));
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = is_skip_op(op) ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch, serial datapath, and result/flag registers that only
  // change on the edge entering FIN so partial results are never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_NOP;
      a_sh     <= '0;
      b_sh     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op;
            a_sh   <= a;
            b_sh   <= b;
            work_q <= '0;
            cnt_q  <= '0;
            c_q    <= (op == OP_SUB);
            if (is_skip_op(op)) begin
              result   <= '0;
              carry    <= 1'b0;
              sign     <= 1'b0;
              zero     <= 1'b1;
              overflow <= 1'b0;
              err      <= is_illegal_op(op);
            end
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          work_q <= work_next;
          c_q    <= co;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            result   <= work_next;
            sign     <= work_next[WIDTH-1];
            zero     <= (work_next == '0);
            // c_q is the carry into the MSB, co the carry out of it.
            carry    <= (op_q == OP_ADD) ? co : ((op_q == OP_SUB) ? ~co : 1'b0);
            overflow <= is_arith & (c_q ^ co);
            err      <= 1'b0;
          end
        end
        ST_FIN: begin
          err <= 1'b0;
        end
        default: begin
          err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_n.sv
// Self-checking bench for serial_alu_n at WIDTH=4 and WIDTH=8.
// Expected results are pushed to a scoreboard queue as each op is issued
// and popped when done is observed.
module tb_serial_alu_n;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       sign;
    logic       zero;
    logic       overflow;
    logic       err;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_in = 1'b0;
  logic [2:0] op_in = 3'b000;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  int         sel = 4;

  logic       busy4, done4, carry4, sign4, zero4, ovf4, err4;
  logic [3:0] result4;
  logic       busy8, done8, carry8, sign8, zero8, ovf8, err8;
  logic [7:0] result8;
  logic       busy_s, done_s;

  res_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_alu_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_in && (sel == 4)), .op(op_in),
    .a(a_in[3:0]), .b(b_in[3:0]), .busy(busy4), .done(done4),
    .result(result4), .carry(carry4), .sign(sign4), .zero(zero4),
    .overflow(ovf4), .err(err4)
  );

  serial_alu_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_in && (sel == 8)), .op(op_in),
    .a(a_in), .b(b_in), .busy(busy8), .done(done8),
    .result(result8), .carry(carry8), .sign(sign8), .zero(zero8),
    .overflow(ovf8), .err(err8)
  );

  assign busy_s = (sel == 8) ? busy8 : busy4;
  assign done_s = (sel == 8) ? done8 : done4;

  function automatic res_t snap();
    res_t r;
    if (sel == 8) r = '{result8, carry8, sign8, zero8, ovf8, err8};
    else          r = '{{4'h0, result4}, carry4, sign4, zero4, ovf4, err4};
    return r;
  endfunction

  // Reference model: plain integer arithmetic on w-bit operands.
  function automatic res_t model(int w, logic [2:0] op, logic [7:0] a, logic [7:0] b);
    res_t e;
    int   ai, bi, s, m;
    bit   sa, sbb, sr;
    m  = (1 << w) - 1;
    ai = int'(a) & m;
    bi = int'(b) & m;
    e  = '0;
    case (op)
      OP_ADD: begin s = ai + bi; e.carry = ((s >> w) & 1) != 0; end
      OP_SUB: begin s = ai - bi; e.carry = (ai < bi); end
      OP_XOR: s = ai ^ bi;
      OP_AND: s = ai & bi;
      OP_OR:  s = ai | bi;
      default: s = 0;
    endcase
    s  = s & m;
    e.result = s[7:0];
    sa  = ((ai >> (w - 1)) & 1) != 0;
    sbb = ((bi >> (w - 1)) & 1) != 0;
    sr  = ((s  >> (w - 1)) & 1) != 0;
    if (op == OP_ADD) e.overflow = (sa == sbb) && (sr != sa);
    if (op == OP_SUB) e.overflow = (sa != sbb) && (sr != sa);
    e.sign = sr;
    e.zero = (s == 0);
    e.err  = (op == 3'b110) || (op == 3'b111);
    return e;
  endfunction

  // Issue one op to the selected DUT and wait (bounded) for done.
  // lat = edges after the start-sampling edge until done is visible.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit disturb, output int lat, output int bcnt);
    sb.push_back(model(sel, op, a, b));
    @(posedge clk); #1;
    op_in = op; a_in = a; b_in = b; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done_s && lat < 40) begin
      if (busy_s) bcnt++;
      if (disturb && lat < 3) begin
        start_in = 1'b1; a_in = ~a; b_in = a; op_in = OP_OR;
      end else begin
        start_in = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    res_t got;
    sel = 4; rst = 1'b1; start_in = 1'b1; op_in = OP_ADD; a_in = 8'h07; b_in = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy4, done4, busy8, done8} !== 4'b0000) begin
      failures++; $display("FAIL reset_handshake got=%b want=0000", {busy4, done4, busy8, done8});
    end
    got = snap();
    checks++;
    if (got !== res_t'(0)) begin failures++; $display("FAIL reset_outputs4 got=%h want=0", got); end
    sel = 8; got = snap(); sel = 4;
    checks++;
    if (got !== res_t'(0)) begin failures++; $display("FAIL reset_outputs8 got=%h want=0", got); end
    rst = 1'b0; start_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_start_dropped busy=%b want=0", busy4); end
  endtask

  task automatic test_arith();
    logic [2:0] ops[4] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB};
    logic [7:0] as[4]  = '{8'h7, 8'h7, 8'h3, 8'h8};
    logic [7:0] bs[4]  = '{8'h9, 8'h1, 8'h5, 8'h1};
    int lat, bc;
    res_t exp, got;
    sel = 4;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 1'b0, lat, bc);
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL arith_latency[%0d] got=%0d want=4", i, lat); end
      exp = sb.pop_front(); got = snap();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL arith_result[%0d] got=%h want=%h", i, got, exp); end
    end
  endtask

  task automatic test_logic();
    logic [2:0] ops[4] = '{OP_XOR, OP_OR, OP_AND, OP_NOP};
    logic [7:0] as[4]  = '{8'hA, 8'hA, 8'hC, 8'h5};
    logic [7:0] bs[4]  = '{8'hA, 8'h5, 8'hA, 8'h3};
    int lat, bc, want_lat;
    res_t exp, got;
    sel = 4;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 1'b0, lat, bc);
      want_lat = (ops[i] == OP_NOP) ? 0 : 4;
      checks++;
      if (lat !== want_lat) begin failures++; $display("FAIL logic_latency[%0d] got=%0d want=%0d", i, lat, want_lat); end
      exp = sb.pop_front(); got = snap();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL logic_result[%0d] got=%h want=%h", i, got, exp); end
    end
  endtask

  task automatic test_handshake();
    int lat, bc;
    res_t exp, got, later;
    sel = 4;
    issue(OP_ADD, 8'h7, 8'h1, 1'b1, lat, bc);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL hs_latency got=%0d want=4", lat); end
    checks++;
    if (bc !== 4) begin failures++; $display("FAIL hs_busy_cycles got=%0d want=4", bc); end
    exp = sb.pop_front(); got = snap();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL hs_result got=%h want=%h", got, exp); end
    @(posedge clk); #1;
    later = snap();
    checks++;
    if ({done_s, busy_s} !== 2'b00) begin failures++; $display("FAIL hs_idle_after got=%b want=00", {done_s, busy_s}); end
    checks++;
    if (later !== exp) begin failures++; $display("FAIL hs_result_held got=%h want=%h", later, exp); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    res_t exp, got;
    sel = 4;
    @(posedge clk); #1;
    op_in = OP_ADD; a_in = 8'h3; b_in = 8'h2; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy_s, done_s} !== 2'b00) begin failures++; $display("FAIL rstmid_handshake got=%b want=00", {busy_s, done_s}); end
    got = snap();
    checks++;
    if (got !== res_t'(0)) begin failures++; $display("FAIL rstmid_outputs got=%h want=0", got); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done_s) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d want=0", seen); end
    issue(OP_SUB, 8'h6, 8'h2, 1'b0, lat, bc);
    exp = sb.pop_front(); got = snap();
    checks++;
    if (got !== exp || lat !== 4) begin
      failures++; $display("FAIL rstmid_fresh_sub got=%h lat=%0d want=%h lat=4", got, lat, exp);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] ops[2] = '{3'b111, 3'b110};
    int lat, bc;
    res_t exp, got;
    sel = 4;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 8'h9, 8'h3, 1'b0, lat, bc);
      checks++;
      if (lat !== 0) begin failures++; $display("FAIL illegal_latency[%0d] got=%0d want=0", i, lat); end
      exp = sb.pop_front(); got = snap();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL illegal_result[%0d] got=%h want=%h", i, got, exp); end
      @(posedge clk); #1;
      checks++;
      if ({done_s, err4} !== 2'b00) begin failures++; $display("FAIL illegal_err_pulse[%0d] got=%b want=00", i, {done_s, err4}); end
    end
  endtask

  task automatic test_width8();
    logic [2:0] ops[3] = '{OP_SUB, OP_ADD, OP_XOR};
    logic [7:0] as[3]  = '{8'h80, 8'hFF, 8'hA5};
    logic [7:0] bs[3]  = '{8'h01, 8'h01, 8'h0F};
    int lat, bc;
    res_t exp, got;
    sel = 8;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i], 1'b0, lat, bc);
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL w8_latency[%0d] got=%0d want=8", i, lat); end
      exp = sb.pop_front(); got = snap();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL w8_result[%0d] got=%h want=%h", i, got, exp); end
    end
    sel = 4;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_handshake();
    test_reset_mid();
    test_illegal();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
